// File: rtl/serial_signed_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B - BORROW_IN, one full-adder
// slice per clock, computed as A + ~B + ~BORROW_IN with a START/BUSY/DONE handshake.
module serial_signed_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             BORROW_IN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] DIFF,
   output logic             BORROW,
   output logic             OVERFLOW
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // One full-adder slice; returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      logic s;
      logic co;
      s  = x ^ y ^ ci;
      co = (x & y) | (x & ci) | (y & ci);
      return {co, s};
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             c_q, c_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [1:0]       slice_s;
   logic [WIDTH-1:0] res_next_s;

   // Current slice: operands are rotated so bit i of each sits at position 0.
   always_comb begin
      slice_s    = full_add(a_q[0], ~b_q[0], c_q);
      res_next_s = {slice_s[0], res_q[WIDTH-1:1]};
   end

   // Next-state, datapath and registered-output logic.
   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      res_d      = res_q;
      c_d        = c_q;
      cnt_d      = cnt_q;
      diff_d     = diff_q;
      borrow_d   = borrow_q;
      overflow_d = overflow_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               a_d     = A;
               b_d     = B;
               c_d     = ~BORROW_IN;
               cnt_d   = {CW{1'b0}};
               res_d   = {WIDTH{1'b0}};
               state_d = ST_SHIFT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            // Rotating (not shifting) keeps the operand MSBs at bit 0 on the last slice.
            a_d   = {a_q[0], a_q[WIDTH-1:1]};
            b_d   = {b_q[0], b_q[WIDTH-1:1]};
            res_d = res_next_s;
            c_d   = slice_s[1];
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == LAST_BIT) begin
               diff_d     = res_next_s;
               borrow_d   = ~slice_s[1];
               overflow_d = (a_q[0] != b_q[0]) && (slice_s[0] != a_q[0]);
               state_d    = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         a_q        <= {WIDTH{1'b0}};
         b_q        <= {WIDTH{1'b0}};
         res_q      <= {WIDTH{1'b0}};
         c_q        <= 1'b0;
         cnt_q      <= {CW{1'b0}};
         diff_q     <= {WIDTH{1'b0}};
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         res_q      <= res_d;
         c_q        <= c_d;
         cnt_q      <= cnt_d;
         diff_q     <= diff_d;
         borrow_q   <= borrow_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign BUSY     = busy_q;
   assign DONE     = done_q;
   assign DIFF     = diff_q;
   assign BORROW   = borrow_q;
   assign OVERFLOW = overflow_q;

endmodule
